// File: rtl/spi_regbank_bridge.sv
// SPI mode-0 slave: decodes command/data frames into register-bank writes and serves reads on MISO.
// Optional sticky framing-error detection is built only when SPI_REGBANK_BRIDGE_ERR_EN is defined.
module spi_regbank_bridge #(
   parameter int unsigned REG_WIDTH = 32,
   parameter int unsigned REG_COUNT = 16,
   localparam int unsigned ADDR_W = $clog2(REG_COUNT)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 spi_sclk,
   input  logic                 spi_cs_n,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   output logic                 rb_we,
   output logic [ADDR_W-1:0]    rb_waddr,
   output logic [REG_WIDTH-1:0] rb_wdata,
   output logic [ADDR_W-1:0]    rb_raddr1,
   input  logic [REG_WIDTH-1:0] rb_rdata1,
   output logic                 frame_err
);

   localparam int unsigned CNT_W = $clog2(((REG_WIDTH > 8) ? REG_WIDTH : 8) + 1);
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(REG_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, WAIT} state_t;

   state_t                state, state_next;
   logic                  sclk_meta, sclk_s, sclk_d;
   logic                  cs_meta, cs_s, cs_d;
   logic                  mosi_meta, mosi_s;
   logic                  sclk_rise, sclk_fall, cs_fall;
   logic [CNT_W-1:0]      bit_cnt;
   logic [REG_WIDTH-1:0]  rx_sr, tx_sr;
   logic                  tx_load;
   logic                  cmd_is_write;
   logic [ADDR_W-1:0]     cmd_addr;

   // cs_n chain resets low so a frame already in progress at reset release is not mistaken for a new one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_meta <= 1'b0;
         sclk_s    <= 1'b0;
         sclk_d    <= 1'b0;
         cs_meta   <= 1'b0;
         cs_s      <= 1'b0;
         cs_d      <= 1'b0;
         mosi_meta <= 1'b0;
         mosi_s    <= 1'b0;
      end else begin
         sclk_meta <= spi_sclk;
         sclk_s    <= sclk_meta;
         sclk_d    <= sclk_s;
         cs_meta   <= spi_cs_n;
         cs_s      <= cs_meta;
         cs_d      <= cs_s;
         mosi_meta <= spi_mosi;
         mosi_s    <= mosi_meta;
      end
   end

   assign sclk_rise    = sclk_s & ~sclk_d;
   assign sclk_fall    = ~sclk_s & sclk_d;
   assign cs_fall      = cs_d & ~cs_s;
   assign cmd_is_write = rx_sr[6];
   assign cmd_addr     = ADDR_W'({rx_sr[6:0], mosi_s});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:         if (cs_fall) state_next = CMD;
         CMD:          if (sclk_rise && bit_cnt == CMD_LAST)
                          state_next = cmd_is_write ? WDATA : RDATA;
         WDATA, RDATA: if (sclk_rise && bit_cnt == DATA_LAST) state_next = WAIT;
         WAIT:         state_next = WAIT;
         default:      state_next = IDLE;
      endcase
      if (cs_s && state != IDLE) state_next = IDLE;
   end

   // Datapath: bit counting, shifting, bank-side strobes and MISO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         tx_load   <= 1'b0;
         spi_miso  <= 1'b0;
         rb_we     <= 1'b0;
         rb_waddr  <= '0;
         rb_wdata  <= '0;
         rb_raddr1 <= '0;
      end else begin
         rb_we   <= 1'b0;
         tx_load <= 1'b0;

         if (state != state_next) bit_cnt <= '0;
         else if (sclk_rise && state inside {CMD, WDATA, RDATA}) bit_cnt <= bit_cnt + CNT_W'(1);

         if (state == IDLE) rx_sr <= '0;
         else if (sclk_rise && state inside {CMD, WDATA}) rx_sr <= {rx_sr[REG_WIDTH-2:0], mosi_s};

         if (state == CMD && state_next == WDATA) rb_waddr <= cmd_addr;
         if (state == CMD && state_next == RDATA) begin
            rb_raddr1 <= cmd_addr;
            tx_load   <= 1'b1;
         end
         if (state == WDATA && state_next == WAIT) begin
            rb_we    <= 1'b1;
            rb_wdata <= {rx_sr[REG_WIDTH-2:0], mosi_s};
         end

         // rdata1 is sampled one cycle after raddr1 settles; first fall comes later
         if (tx_load) tx_sr <= rb_rdata1;
         else if (state == RDATA && sclk_fall) tx_sr <= {tx_sr[REG_WIDTH-2:0], 1'b0};

         if (state != RDATA) spi_miso <= 1'b0;
         else if (sclk_fall && !tx_load) spi_miso <= tx_sr[REG_WIDTH-1];
      end
   end

`ifdef SPI_REGBANK_BRIDGE_ERR_EN
   // Sticky: frame ended by cs_n with bits counted inside an active phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_err <= 1'b0;
      else if (cs_s && bit_cnt != '0 && state inside {CMD, WDATA, RDATA}) frame_err <= 1'b1;
   end
`else
   assign frame_err = 1'b0;
`endif

endmodule
